// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, fixed DWIDTH+1 cycle latency, registered result.
module mul_div_unit #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              MD_Start,
  input  logic [2:0]        MD_OP,
  input  logic [DWIDTH-1:0] MD_In_A,
  input  logic [DWIDTH-1:0] MD_In_B,
  output logic [DWIDTH-1:0] MD_Out,
  output logic              MD_Busy,
  output logic              MD_Done
);

  localparam int unsigned CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [DWIDTH-1:0] m_q, m_d;
  logic [DWIDTH-1:0] hi_q, hi_d;
  logic [DWIDTH-1:0] lo_q, lo_d;
  logic [DWIDTH-1:0] a_orig_q, a_orig_d;
  logic              neg_q, neg_d;
  logic              neg_a_q, neg_a_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic [DWIDTH-1:0] out_q, out_d;
  logic              done_q, done_d;

  // Operand sign decode at latch time
  logic              a_sgn, b_sgn, sa, sb;
  logic [DWIDTH-1:0] mag_a, mag_b;

  assign a_sgn = (MD_OP == 3'b001) || (MD_OP == 3'b010) || (MD_OP == 3'b100) || (MD_OP == 3'b110);
  assign b_sgn = (MD_OP == 3'b001) || (MD_OP == 3'b100) || (MD_OP == 3'b110);
  assign sa    = a_sgn & MD_In_A[DWIDTH-1];
  assign sb    = b_sgn & MD_In_B[DWIDTH-1];
  assign mag_a = sa ? -MD_In_A : MD_In_A;
  assign mag_b = sb ? -MD_In_B : MD_In_B;

  // One multiply step: conditional add of multiplicand, then shift {carry,hi,lo} right
  logic [DWIDTH:0] mul_sum;
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(DWIDTH+1){1'b0}});

  // One restoring-divide step; the true difference always fits DWIDTH bits when taken
  logic [DWIDTH:0]   div_shift;
  logic              div_ok;
  logic [DWIDTH-1:0] div_diff;
  assign div_shift = {hi_q, lo_q[DWIDTH-1]};
  assign div_ok    = div_shift[DWIDTH] | (div_shift[DWIDTH-1:0] >= m_q);
  assign div_diff  = div_shift[DWIDTH-1:0] - m_q;

  // Sign fix-up and result select
  logic [2*DWIDTH-1:0] prod, prod_s;
  logic [DWIDTH-1:0]   quo_s, rem_s, result_c;

  assign prod   = {hi_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -lo_q : lo_q;
  assign rem_s  = neg_a_q ? -hi_q : hi_q;

  always_comb begin
    result_c = '0;
    if (op_q[2]) begin
      if (op_q[1]) result_c = dz_q ? a_orig_q : (ovf_q ? '0 : rem_s);
      else         result_c = dz_q ? '1 : (ovf_q ? a_orig_q : quo_s);
    end else begin
      result_c = (op_q[1:0] == 2'b00) ? prod_s[DWIDTH-1:0] : prod_s[2*DWIDTH-1:DWIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_orig_d = a_orig_q;
    neg_d    = neg_q;
    neg_a_d  = neg_a_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    out_d    = out_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MD_Start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          op_d     = MD_OP;
          hi_d     = '0;
          m_d      = MD_OP[2] ? mag_b : mag_a;
          lo_d     = MD_OP[2] ? mag_a : mag_b;
          a_orig_d = MD_In_A;
          neg_d    = sa ^ sb;
          neg_a_d  = sa;
          dz_d     = (MD_In_B == '0);
          ovf_d    = a_sgn && b_sgn && MD_OP[2] &&
                     (MD_In_A == {1'b1, {(DWIDTH-1){1'b0}}}) && (MD_In_B == '1);
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          hi_d = div_ok ? div_diff : div_shift[DWIDTH-1:0];
          lo_d = {lo_q[DWIDTH-2:0], div_ok};
        end else begin
          hi_d = mul_sum[DWIDTH:1];
          lo_d = {mul_sum[0], lo_q[DWIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DWIDTH-1)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        out_d   = result_c;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_orig_q <= '0;
      neg_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_orig_q <= a_orig_d;
      neg_q    <= neg_d;
      neg_a_q  <= neg_a_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign MD_Busy = (state_q != S_IDLE);
  assign MD_Out  = out_q;
  assign MD_Done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, reset abort and start handshake.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        MD_Start;
  logic [2:0]  MD_OP;
  logic [31:0] MD_In_A, MD_In_B, MD_Out;
  logic        MD_Busy, MD_Done;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.DWIDTH(32)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .MD_Start(MD_Start), .MD_OP(MD_OP),
    .MD_In_A(MD_In_A), .MD_In_B(MD_In_B), .MD_Out(MD_Out),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present a request, let the next edge sample it, then scramble the inputs
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MD_OP    = op;
    MD_In_A  = a;
    MD_In_B  = b;
    MD_Start = 1'b1;
    step();
    MD_Start = 1'b0;
    MD_OP    = ~op;
    MD_In_A  = $urandom;
    MD_In_B  = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!MD_Done && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  // Start an op, confirm busy/done after the start edge, then check latency and result
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int c;
    start_op(op, a, b);
    check({tag, "_busy"}, 32'(MD_Busy), 32'd1);
    check({tag, "_done_low"}, 32'(MD_Done), 32'd0);
    wait_done(c);
    check({tag, "_latency"}, 32'(c), 32'd33);
    check(tag, MD_Out, exp);
  endtask

  initial begin
    int c;
    int n;
    Reset_N  = 1'b0;
    MD_Start = 1'b0;
    MD_OP    = '0;
    MD_In_A  = '0;
    MD_In_B  = '0;
    repeat (3) step();
    check("rst_busy", 32'(MD_Busy), 32'd0);
    check("rst_done", 32'(MD_Done), 32'd0);
    check("rst_out", MD_Out, 32'd0);
    Reset_N = 1'b1;
    step();

    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);

    // Abort an operation mid-CALC
    step();
    start_op(OP_MUL, 32'd3, 32'd5);
    repeat (10) step();
    Reset_N = 1'b0;
    #1;
    check("abort_busy", 32'(MD_Busy), 32'd0);
    check("abort_out", MD_Out, 32'd0);
    check("abort_done", 32'(MD_Done), 32'd0);
    step();
    step();
    Reset_N = 1'b1;
    n = 0;
    repeat (40) begin
      step();
      if (MD_Done) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    check("abort_out_held", MD_Out, 32'd0);

    run("mul_7_6", OP_MUL, 32'd7, 32'd6, 32'h0000002A);

    // Back-to-back: each run starts in the previous done cycle
    run("mul_m1",    OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run("mulh_m1",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run("mulhu_m1",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("mulhsu_m1", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run("mulh_mix",  OP_MULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);

    run("div_m7_2",  OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run("rem_m7_2",  OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run("divu_m7_2", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC);
    run("remu_m7_2", OP_REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001);
    run("div_7_m2",  OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    run("rem_7_m2",  OP_REM,  32'd7, 32'hFFFFFFFE, 32'h00000001);

    run("divu_5_0",  OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
    run("remu_5_0",  OP_REMU, 32'd5, 32'd0, 32'h00000005);
    run("div_m7_0",  OP_DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
    run("rem_m7_0",  OP_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
    run("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run("rem_ovf",   OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    // A start pulse while busy must be ignored and not queued
    step();
    check("dbl_done_pulse", 32'(MD_Done), 32'd0);
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (5) step();
    MD_OP    = OP_MUL;
    MD_In_A  = 32'd3;
    MD_In_B  = 32'd3;
    MD_Start = 1'b1;
    step();
    MD_Start = 1'b0;
    check("ign_busy", 32'(MD_Busy), 32'd1);
    wait_done(c);
    check("ign_latency", 32'(c), 32'd27);
    check("ign_result", MD_Out, 32'd14);
    n = 0;
    repeat (40) begin
      step();
      if (MD_Done) n++;
    end
    check("ign_not_queued", 32'(n), 32'd0);
    check("ign_out_held", MD_Out, 32'd14);
    check("ign_idle", 32'(MD_Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit. It sits beside the single-cycle ALU in the execute stage and handles the M-extension operations that the combinational ALU does not implement. It accepts one operation per start pulse, runs a fixed-latency radix-2 shift-add multiply or restoring divide, and returns a registered result with a one-cycle done pulse. The core stalls on `MD_Busy`.

## Interface
- `DWIDTH`, default 32: operand and result width; iteration count equals `DWIDTH`.

Ports (clock and reset first):
- `Clk`  input  1  rising-edge clock; the only clock.
- `Reset_N`  input  1  asynchronous, active-low reset.
- `MD_Start`  input  1  request; sampled only when `MD_Busy`=0.
- `MD_OP`  input  3  operation, RV32M funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `MD_In_A`  input  DWIDTH  operand A (multiplicand / dividend).
- `MD_In_B`  input  DWIDTH  operand B (multiplier / divisor).
- `MD_Out`  output  DWIDTH  result; registered; holds its value until the next done.
- `MD_Busy`  output  1  high while an operation is in flight.
- `MD_Done`  output  1  one-cycle pulse; `MD_Out` is valid in the same cycle.

## Operation
- FSM states: IDLE, CALC, FIN.
  - IDLE: when `MD_Start`=1, latch `MD_OP`, A and B, then go to CALC with the iteration counter at 0. Inputs may change after this edge.
  - CALC: one iteration per cycle. After `DWIDTH` iterations, go to FIN.
  - FIN: apply sign fix-up, register `MD_Out`, pulse `MD_Done`, return to IDLE.
- `MD_Busy` = 1 in CALC and FIN; 0 in IDLE. It is a combinational decode of the state register.
- Signedness at latch:
  - A is signed for MULH, MULHSU, DIV, REM.
  - B is signed for MULH, DIV, REM.
  - Signed operands are converted to magnitude. The result-negate flag is recorded.
- Multiply:
  - Unsigned 2·`DWIDTH`-bit shift-add on the magnitudes.
  - The product is negated in FIN if the operand signs differ.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide:
  - Restoring, unsigned, on the magnitudes.
  - Quotient is negated if signs differ. Remainder takes the sign of the dividend.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (same fixed latency, no early exit):
  - Divide by zero: quotient = all ones; remainder = A (original, unnegated).
  - Signed overflow (A = most-negative, B = −1, DIV/REM): quotient = A; remainder = 0.
- `MD_Start` while `MD_Busy`=1 is ignored. No queuing; the latched operation is unaffected.

## Timing
- Reset (async assert, any state): state goes to IDLE; `MD_Out`=0, `MD_Busy`=0, `MD_Done`=0; counter and datapath registers are cleared. An operation in flight is abandoned and no `MD_Done` is issued for it.
- Start sampled at edge k:
  - `MD_Busy` is high after edges k through k+`DWIDTH`.
  - The FIN→IDLE transition happens at edge k+`DWIDTH`+1. `MD_Done`=1 and `MD_Out` are valid for the one cycle after that edge.
  - Latency is `DWIDTH`+1 cycles from the start edge (33 for `DWIDTH`=32).
- Back-to-back: `MD_Busy` is 0 in the done cycle, so a new `MD_Start` is accepted in that same cycle. Throughput is one operation per `DWIDTH`+1 cycles.
- `MD_Done` never stays high for two consecutive cycles.
- `MD_Out` changes only on done edges and on reset.

## Test plan
- Reset: assert `Reset_N`=0 mid-CALC → `MD_Busy`=0, `MD_Out`=0, `MD_Done` low. Release reset, then run MUL 7·6 → `MD_Out`=0x0000002A, `MD_Done` exactly 33 cycles after start.
- Multiply variants, all with A=B=0xFFFFFFFF:
  - MUL → 0x00000001
  - MULH → 0x00000000
  - MULHU → 0xFFFFFFFE
  - MULHSU → 0xFFFFFFFF
- Signed divide, A=0xFFFFFFF9 (−7), B=2:
  - DIV → 0xFFFFFFFD
  - REM → 0xFFFFFFFF
  - DIVU → 0x7FFFFFFC
  - REMU → 0x00000001
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0x00000000.
  - All of the above complete in 33 cycles.
- Handshake:
  - Pulse `MD_Start` with different operands while busy → the original result is returned unchanged.
  - Assert `MD_Start` in the `MD_Done` cycle → it is accepted, and the second `MD_Done` arrives 33 cycles later.
  - Change operand inputs after the start edge → the result still reflects the latched values.
